// File: rtl/nist04_pattern_gen.sv
// nist04_pattern_gen: serial stimulus source for the longest-run checker.
// Emits 8-bit blocks, MSB first, whose longest run of ones hits a class.
module nist04_pattern_gen #(
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter bit          FALLBACK_ONLY = 1'b0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic       constrain,
  input  logic [1:0] cls_sel,
  output logic       RND_out,
  output logic       out_valid,
  output logic       blk_start,
  output logic [1:0] blk_class,
  output logic       fallback,
  output logic       frame_done
);

  typedef enum logic {
    PRIME,
    RUN
  } state_e;

  localparam logic [15:0] SEED_EFF =
    (SEED == 16'h0000) ? 16'hACE1 : SEED;

  function automatic logic [1:0] run_class(
    input logic [7:0] v
  );
    logic [3:0] run;
    logic [3:0] best;
    logic [1:0] cls;
    run  = 4'd0;
    best = 4'd0;
    cls  = 2'd0;
    for (int i = 0; i < 8; i++) begin
      run = v[i] ? run + 4'd1 : 4'd0;
      if (run > best) best = run;
    end
    unique case (1'b1)
      (best <= 4'd1): cls = 2'd0;
      (best == 4'd2): cls = 2'd1;
      (best == 4'd3): cls = 2'd2;
      (best >= 4'd4): cls = 2'd3;
    endcase
    return cls;
  endfunction

  function automatic logic [7:0] tmpl(
    input logic [1:0] c
  );
    logic [7:0] t;
    unique case (c)
      2'd0: t = 8'b0101_0101;
      2'd1: t = 8'b0011_0011;
      2'd2: t = 8'b0111_0111;
      2'd3: t = 8'b0000_1111;
    endcase
    return t;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  blk_idx_q, blk_idx_d;
  logic        found_q, found_d;
  logic [1:0]  req_q, req_d;
  logic        mode_q, mode_d;
  logic [7:0]  nxt_blk_q, nxt_blk_d;
  logic        nxt_fb_q, nxt_fb_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        rnd_q, rnd_d;
  logic        valid_q, valid_d;
  logic        start_q, start_d;
  logic [1:0]  class_q, class_d;
  logic        fb_q, fb_d;
  logic        fd_q, fd_d;

  logic        lfsr_fb;
  logic [7:0]  cand;
  logic [1:0]  cand_cls;
  logic        win_start;
  logic        win_end;
  logic [1:0]  req_eff;
  logic        mode_eff;
  logic        found_eff;
  logic        hit;

  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13]
                   ^ lfsr_q[12] ^ lfsr_q[10];
  assign cand      = lfsr_q[7:0];
  assign cand_cls  = run_class(cand);
  assign win_start = bit_cnt_q == 3'd0;
  assign win_end   = bit_cnt_q == 3'd7;
  // Window-opening cycle sees the live request, later cycles the sample.
  assign req_eff   = win_start ? cls_sel : req_q;
  assign mode_eff  = win_start ? constrain : mode_q;
  assign found_eff = win_start ? 1'b0 : found_q;
  assign hit       = !FALLBACK_ONLY && !found_eff
                   && (cand_cls == req_eff);

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    bit_cnt_d = bit_cnt_q;
    blk_idx_d = blk_idx_q;
    found_d   = found_q;
    req_d     = req_q;
    mode_d    = mode_q;
    nxt_blk_d = nxt_blk_q;
    nxt_fb_d  = nxt_fb_q;
    shreg_d   = shreg_q;
    rnd_d     = rnd_q;
    valid_d   = valid_q;
    start_d   = 1'b0;
    class_d   = class_q;
    fb_d      = fb_q;
    fd_d      = 1'b0;
    if (en) begin
      lfsr_d    = {lfsr_q[14:0], lfsr_fb};
      bit_cnt_d = bit_cnt_q + 3'd1;
      found_d   = found_eff;
      if (win_start) begin
        req_d  = cls_sel;
        mode_d = constrain;
      end
      if (hit) begin
        nxt_blk_d = cand;
        nxt_fb_d  = 1'b0;
        found_d   = 1'b1;
      end
      if (win_end) begin
        if (FALLBACK_ONLY) begin
          nxt_blk_d = tmpl(req_eff);
          nxt_fb_d  = 1'b1;
        end else if (!mode_eff) begin
          nxt_blk_d = cand;
          nxt_fb_d  = 1'b0;
        end else if (!found_eff && !hit) begin
          nxt_blk_d = tmpl(req_eff);
          nxt_fb_d  = 1'b1;
        end
      end
      unique case (state_q)
        PRIME: begin
          rnd_d   = 1'b0;
          valid_d = 1'b0;
          if (win_end) state_d = RUN;
        end
        RUN: begin
          if (win_start) begin
            shreg_d = {nxt_blk_q[6:0], 1'b0};
            rnd_d   = nxt_blk_q[7];
            class_d = run_class(nxt_blk_q);
            fb_d    = nxt_fb_q;
            start_d = 1'b1;
            valid_d = 1'b1;
          end else begin
            shreg_d = {shreg_q[6:0], 1'b0};
            rnd_d   = shreg_q[7];
          end
          if (win_end) begin
            fd_d      = blk_idx_q == 4'd15;
            blk_idx_d = blk_idx_q + 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= PRIME;
      lfsr_q    <= SEED_EFF;
      bit_cnt_q <= 3'd0;
      blk_idx_q <= 4'd0;
      found_q   <= 1'b0;
      req_q     <= 2'd0;
      mode_q    <= 1'b0;
      nxt_blk_q <= 8'd0;
      nxt_fb_q  <= 1'b0;
      shreg_q   <= 8'd0;
      rnd_q     <= 1'b0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      class_q   <= 2'd0;
      fb_q      <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      bit_cnt_q <= bit_cnt_d;
      blk_idx_q <= blk_idx_d;
      found_q   <= found_d;
      req_q     <= req_d;
      mode_q    <= mode_d;
      nxt_blk_q <= nxt_blk_d;
      nxt_fb_q  <= nxt_fb_d;
      shreg_q   <= shreg_d;
      rnd_q     <= rnd_d;
      valid_q   <= valid_d;
      start_q   <= start_d;
      class_q   <= class_d;
      fb_q      <= fb_d;
      fd_q      <= fd_d;
    end
  end

  assign RND_out    = rnd_q;
  assign out_valid  = valid_q;
  assign blk_start  = start_q;
  assign blk_class  = class_q;
  assign fallback   = fb_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_nist04_pattern_gen.sv
// tb_nist04_pattern_gen: window-level reference model plus vector table.
// Runs a searching instance and a template-only instance side by side.
module tb_nist04_pattern_gen;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       en = 1'b0;
  logic       constrain = 1'b0;
  logic [1:0] cls_sel = 2'd0;

  logic       r0, v0, s0, fb0, fd0;
  logic [1:0] c0;
  logic       r1, v1, s1, fb1, fd1;
  logic [1:0] c1;

  always #5 clk = ~clk;

  nist04_pattern_gen #(
    .SEED(16'hACE1),
    .FALLBACK_ONLY(1'b0)
  ) u_srch (
    .clk(clk), .rstn(rstn), .en(en),
    .constrain(constrain), .cls_sel(cls_sel),
    .RND_out(r0), .out_valid(v0), .blk_start(s0),
    .blk_class(c0), .fallback(fb0), .frame_done(fd0)
  );

  nist04_pattern_gen #(
    .SEED(16'hACE1),
    .FALLBACK_ONLY(1'b1)
  ) u_tmpl (
    .clk(clk), .rstn(rstn), .en(en),
    .constrain(constrain), .cls_sel(cls_sel),
    .RND_out(r1), .out_valid(v1), .blk_start(s1),
    .blk_class(c1), .fallback(fb1), .frame_done(fd1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int longest(input logic [7:0] v);
    int best;
    int m;
    best = 0;
    for (int len = 1; len <= 8; len++) begin
      m = (1 << len) - 1;
      for (int p = 0; p + len <= 8; p++)
        if (((int'(v) >> p) & m) == m) best = len;
    end
    return best;
  endfunction

  function automatic logic [1:0] cls_of(input logic [7:0] v);
    int l;
    l = longest(v);
    if (l <= 1) return 2'd0;
    if (l == 2) return 2'd1;
    if (l == 3) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [7:0] tmpl(input logic [1:0] c);
    logic [7:0] t [4];
    t[0] = 8'h55;
    t[1] = 8'h33;
    t[2] = 8'h77;
    t[3] = 8'h0F;
    return t[c];
  endfunction

  // reference model state: per-window block choice
  int          m_cyc;
  int          m_blk;
  logic [15:0] m_lfsr;
  logic [1:0]  m_req;
  logic        m_mode;
  logic [7:0]  m_cand [8];
  logic [7:0]  n0, e0, n1, e1;
  logic        nf0, ef0;
  logic [6:0]  x0, x1;

  task automatic model_reset();
    m_cyc  = 0;
    m_blk  = 0;
    m_lfsr = 16'hACE1;
    x0 = '0;
    x1 = '0;
  endtask

  task automatic model_edge(input logic e, input logic cm,
                            input logic [1:0] cs);
    int b;
    int w;
    logic [7:0] blk;
    bit found;
    if (!e) begin
      x0[4] = 1'b0;
      x0[0] = 1'b0;
      x1[4] = 1'b0;
      x1[0] = 1'b0;
      return;
    end
    b = m_cyc % 8;
    w = m_cyc / 8;
    if (b == 0) begin
      m_req  = cs;
      m_mode = cm;
      if (w > 0) begin
        e0 = n0;
        ef0 = nf0;
        e1 = n1;
        m_blk = w - 1;
      end
    end
    m_cand[b] = m_lfsr[7:0];
    if (b == 7) begin
      found = 0;
      blk = tmpl(m_req);
      for (int i = 0; i < 8; i++)
        if (!found && cls_of(m_cand[i]) == m_req) begin
          blk = m_cand[i];
          found = 1;
        end
      if (!m_mode) begin
        n0 = m_cand[7];
        nf0 = 1'b0;
      end else begin
        n0 = blk;
        nf0 = !found;
      end
      n1 = tmpl(m_req);
    end
    m_lfsr = {m_lfsr[14:0],
              m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    if (w == 0) begin
      x0 = '0;
      x1 = '0;
    end else begin
      x0 = {e0[7-b], 1'b1, b == 0, cls_of(e0), ef0,
            b == 7 && m_blk % 16 == 15};
      x1 = {e1[7-b], 1'b1, b == 0, cls_of(e1), 1'b1,
            b == 7 && m_blk % 16 == 15};
    end
    m_cyc++;
  endtask

  task automatic step(input logic e, input logic cm,
                      input logic [1:0] cs);
    en = e;
    constrain = cm;
    cls_sel = cs;
    @(posedge clk);
    #1;
    model_edge(e, cm, cs);
    chk("srch_outs", 32'({r0, v0, s0, c0, fb0, fd0}), 32'(x0));
    chk("tmpl_outs", 32'({r1, v1, s1, c1, fb1, fd1}), 32'(x1));
  endtask

  // asserts reset mid-cycle, checks the async clear, releases off-edge
  task automatic do_reset();
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_srch", 32'({r0, v0, s0, c0, fb0, fd0}), 32'd0);
    chk("rst_tmpl", 32'({r1, v1, s1, c1, fb1, fd1}), 32'd0);
    model_reset();
    en = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic window(input logic cm, input logic [1:0] cs_a,
                        input logic [1:0] cs_b, input int sw,
                        output logic [7:0] by0,
                        output logic [7:0] by1,
                        output logic [1:0] cl0,
                        output logic [1:0] cl1,
                        output logic f1);
    by0 = '0;
    by1 = '0;
    cl0 = '0;
    cl1 = '0;
    f1 = 1'b0;
    for (int b = 0; b < 8; b++) begin
      step(1'b1, cm, (b < sw) ? cs_a : cs_b);
      by0 = {by0[6:0], r0};
      by1 = {by1[6:0], r1};
      if (b == 0) begin
        cl0 = c0;
        cl1 = c1;
        f1 = fb1;
      end
    end
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [7:0] pat;
    logic [1:0] cls;
  } vec_t;

  initial begin
    vec_t tbl [4];
    logic rec [64];
    logic [7:0] by0, by1;
    logic [1:0] cl0, cl1;
    logic f1;
    int fdpos [8];
    int nfd;

    tbl[0] = '{2'd0, 8'b0101_0101, 2'd0};
    tbl[1] = '{2'd1, 8'b0011_0011, 2'd1};
    tbl[2] = '{2'd2, 8'b0111_0111, 2'd2};
    tbl[3] = '{2'd3, 8'b0000_1111, 2'd3};

    // latency, then async reset at bit 3 of block 5
    do_reset();
    for (int i = 0; i < 52; i++) begin
      step(1'b1, 1'b1, 2'd2);
      rec[i] = r0;
      if (i < 8) chk("prime_valid", 32'(v0), 32'd0);
      if (i == 8) chk("first_valid", 32'({v0, s0}), 32'd3);
    end
    chk("pre_rst_valid", 32'(v0), 32'd1);
    do_reset();
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 1'b1, 2'd2);
      if (i == 7) chk("re_prime", 32'(v0), 32'd0);
      if (i == 8) chk("re_valid", 32'({v0, s0}), 32'd3);
      if (i < 52) chk("re_seq", 32'(r0), 32'(rec[i]));
    end

    // template table on the search-disabled instance
    do_reset();
    for (int w = 0; w < 5; w++) begin
      window(1'b1, (w < 4) ? tbl[w].sel : 2'd0,
             (w < 4) ? tbl[w].sel : 2'd0, 8,
             by0, by1, cl0, cl1, f1);
      if (w > 0) begin
        chk("tbl_pat", 32'(by1), 32'(tbl[w-1].pat));
        chk("tbl_cls", 32'(cl1), 32'(tbl[w-1].cls));
        chk("tbl_fb", 32'(f1), 32'd1);
      end
    end

    // request change mid-window takes effect one block later
    do_reset();
    window(1'b1, 2'd0, 2'd0, 8, by0, by1, cl0, cl1, f1);
    window(1'b1, 2'd0, 2'd3, 4, by0, by1, cl0, cl1, f1);
    chk("sw_blk0", 32'(by1), 32'h55);
    window(1'b1, 2'd3, 2'd3, 8, by0, by1, cl0, cl1, f1);
    chk("sw_blk1", 32'(by1), 32'h55);
    window(1'b1, 2'd3, 2'd3, 8, by0, by1, cl0, cl1, f1);
    chk("sw_blk2", 32'(by1), 32'h0F);

    // class 3 for 64 blocks: run length and frame pacing
    do_reset();
    nfd = 0;
    for (int w = 0; w < 65; w++) begin
      for (int b = 0; b < 8; b++) begin
        step(1'b1, 1'b1, 2'd3);
        by0 = {by0[6:0], r0};
        if (w > 0 && b == 0) chk("c3_cls", 32'(c0), 32'd3);
        if (fd0) begin
          if (nfd < 8) fdpos[nfd] = w * 8 + b;
          nfd++;
        end
      end
      if (w > 0) chk("c3_run", 32'(longest(by0) >= 4), 32'd1);
    end
    chk("fd_count", 32'(nfd), 32'd4);
    for (int i = 1; i < nfd && i < 8; i++)
      chk("fd_gap", 32'(fdpos[i] - fdpos[i-1]), 32'd128);

    // random mode and class, changing every cycle
    do_reset();
    for (int i = 0; i < 640; i++)
      step(1'b1, 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)));

    // raw LFSR blocks only
    do_reset();
    for (int i = 0; i < 160; i++)
      step(1'b1, 1'b0, 2'($urandom_range(0, 3)));

    // enable toggling every cycle
    do_reset();
    for (int i = 0; i < 400; i++)
      step(1'(i % 2 == 0), 1'b1, 2'($urandom_range(0, 3)));

    // random enable pattern
    do_reset();
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
